// File: rtl/aclk_load_arbiter.sv
// Two-requester load-port arbiter for the aclock core: validates BCD hh:mm, strobes the load and verifies time loads by readback.
// Optional build macro ACLK_ARB_RR_EN selects round-robin tie-breaking instead of fixed priority.
module aclk_load_arbiter #(
    parameter int unsigned SETTLE_CYC    = 2,
    parameter bit          VERIFY_EN_DEF = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  kind,
    input  logic [11:0] hh_bcd,
    input  logic [15:0] mm_bcd,
    output logic [1:0]  ack,
    output logic        ack_err,
    output logic        busy,
    output logic [1:0]  H_in1,
    output logic [3:0]  H_in0,
    output logic [3:0]  M_in1,
    output logic [3:0]  M_in0,
    output logic        LD_time,
    output logic        LD_alarm,
    input  logic [1:0]  H_out1,
    input  logic [3:0]  H_out0,
    input  logic [3:0]  M_out1,
    input  logic [3:0]  M_out0
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        VERIFY = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state;
    logic        win;
    logic        lat_kind;
    logic [13:0] lat_val;
    logic [3:0]  cnt;

    logic        pick;
    logic [13:0] pick_val;
    logic [13:0] readback;
    logic        payload_ok;

`ifdef ACLK_ARB_RR_EN
    logic        last_grant;

    // On a tie the requester not granted last wins; a lone requester always wins.
    always_comb begin
        pick = req[1];
        if (req == 2'b11) begin
            pick = ~last_grant;
        end
    end
`else
    always_comb begin
        pick = ~req[0];
    end
`endif

    always_comb begin
        pick_val = pick ? {hh_bcd[11:6], mm_bcd[15:8]} : {hh_bcd[5:0], mm_bcd[7:0]};
        readback = {H_out1, H_out0, M_out1, M_out0};
    end

    // Layout of lat_val: {H1[1:0], H0[3:0], M1[3:0], M0[3:0]}.
    always_comb begin
        payload_ok = (lat_val[13:12] <= 2'd2) &&
                     (lat_val[11:8]  <= 4'd9) &&
                     ((lat_val[13:12] != 2'd2) || (lat_val[11:8] <= 4'd3)) &&
                     (lat_val[7:4]   <= 4'd5) &&
                     (lat_val[3:0]   <= 4'd9);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            win      <= 1'b0;
            lat_kind <= 1'b0;
            lat_val  <= '0;
            cnt      <= '0;
            ack      <= '0;
            ack_err  <= 1'b0;
            busy     <= 1'b0;
            H_in1    <= '0;
            H_in0    <= '0;
            M_in1    <= '0;
            M_in0    <= '0;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
`ifdef ACLK_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            ack      <= '0;
            ack_err  <= 1'b0;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        win      <= pick;
                        lat_kind <= kind[pick];
                        lat_val  <= pick_val;
                        busy     <= 1'b1;
                        state    <= CHECK;
`ifdef ACLK_ARB_RR_EN
                        last_grant <= pick;
`endif
                    end
                end
                CHECK: begin
                    if (payload_ok) begin
                        {H_in1, H_in0, M_in1, M_in0} <= lat_val;
                        LD_time  <= ~lat_kind;
                        LD_alarm <= lat_kind;
                        cnt      <= 4'(SETTLE_CYC);
                        state    <= LOAD;
                    end else begin
                        ack     <= win ? 2'b10 : 2'b01;
                        ack_err <= 1'b1;
                        state   <= RESP;
                    end
                end
                LOAD: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= VERIFY;
                    end
                end
                VERIFY: begin
                    ack     <= win ? 2'b10 : 2'b01;
                    ack_err <= (VERIFY_EN_DEF && !lat_kind) ? (readback != lat_val) : 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_load_arbiter.sv
// Directed bench for aclk_load_arbiter: vector table of single loads plus tie-arbitration and mid-transaction reset sequences.
module tb_aclk_load_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  kind = '0;
    logic [11:0] hh_bcd = '0;
    logic [15:0] mm_bcd = '0;
    logic [1:0]  ack, nv_ack;
    logic        ack_err, nv_ack_err;
    logic        busy, nv_busy;
    logic [1:0]  H_in1, nv_H_in1;
    logic [3:0]  H_in0, M_in1, M_in0, nv_H_in0, nv_M_in1, nv_M_in0;
    logic        LD_time, LD_alarm, nv_LD_time, nv_LD_alarm;
    logic [1:0]  H_out1;
    logic [3:0]  H_out0, M_out1, M_out0;

    logic [13:0] model_time;
    logic [13:0] cmask = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // aclock stand-in: captures time loads, readback optionally corrupted by cmask.
    always_ff @(posedge clk) begin
        if (LD_time) model_time <= {H_in1, H_in0, M_in1, M_in0};
    end
    assign {H_out1, H_out0, M_out1, M_out0} = model_time ^ cmask;

    aclk_load_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .kind(kind), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd),
        .ack(ack), .ack_err(ack_err), .busy(busy),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0)
    );

    aclk_load_arbiter #(.SETTLE_CYC(2), .VERIFY_EN_DEF(1'b0)) dut_nv (
        .clk(clk), .reset(reset), .req(req), .kind(kind), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd),
        .ack(nv_ack), .ack_err(nv_ack_err), .busy(nv_busy),
        .H_in1(nv_H_in1), .H_in0(nv_H_in0), .M_in1(nv_M_in1), .M_in0(nv_M_in0),
        .LD_time(nv_LD_time), .LD_alarm(nv_LD_alarm),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0)
    );

    typedef struct {
        int          r;
        logic        k;
        logic [5:0]  hh;
        logic [7:0]  mm;
        logic [13:0] cmask;
        logic        exp_err;
        logic        exp_err_nv;
        int          exp_lat;
        logic        strobe;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [13:0] prev;
        logic [1:0]  ack_s;
        logic        err_s, err_nv_s, nv_ack_ok, got;
        int          n, nlt, nla;
        @(negedge clk);
        prev = {H_in1, H_in0, M_in1, M_in0};
        cmask = v.cmask;
        kind[v.r] = v.k;
        hh_bcd[6*v.r +: 6] = v.hh;
        mm_bcd[8*v.r +: 8] = v.mm;
        req[v.r] = 1'b1;
        n = 0; nlt = 0; nla = 0; got = 1'b0;
        ack_s = '0; err_s = 1'b0; err_nv_s = 1'b0; nv_ack_ok = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("busy_after_grant", busy, 1);
            if (LD_time || LD_alarm) chk("digits_in_strobe", {H_in1, H_in0, M_in1, M_in0}, {v.hh, v.mm});
            nlt += int'(LD_time);
            nla += int'(LD_alarm);
            if (ack != 2'b00) begin
                got = 1'b1;
                ack_s = ack;
                err_s = ack_err;
                err_nv_s = nv_ack_err;
                nv_ack_ok = (nv_ack == ack);
            end
        end
        chk("ack_seen", got, 1);
        chk("ack_who", ack_s, (v.r == 1) ? 2 : 1);
        chk("latency", n + 1, v.exp_lat);
        chk("ack_err", err_s, v.exp_err);
        chk("nv_ack_same_cycle", nv_ack_ok, 1);
        chk("nv_ack_err", err_nv_s, v.exp_err_nv);
        chk("ld_time_pulses", nlt, (v.strobe && !v.k) ? 1 : 0);
        chk("ld_alarm_pulses", nla, (v.strobe && v.k) ? 1 : 0);
        chk("digits_hold", {H_in1, H_in0, M_in1, M_in0}, v.strobe ? {v.hh, v.mm} : prev);
        @(negedge clk);
        req[v.r] = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", ack, 0);
        chk("busy_back_idle", busy, 0);
    endtask

    initial begin
        int          grants[4];
        int          exp_g[4];
        int          ng, cyc;

        vecs[0] = '{0, 1'b0, 6'h12, 8'h34, 14'h0000, 1'b0, 1'b0, 7, 1'b1};
        vecs[1] = '{1, 1'b1, 6'h07, 8'h05, 14'h3fff, 1'b0, 1'b0, 7, 1'b1};
        vecs[2] = '{0, 1'b0, 6'h24, 8'h00, 14'h0000, 1'b1, 1'b1, 3, 1'b0};
        vecs[3] = '{0, 1'b0, 6'h19, 8'h60, 14'h0000, 1'b1, 1'b1, 3, 1'b0};
        vecs[4] = '{0, 1'b0, 6'h08, 8'h15, 14'h0003, 1'b1, 1'b0, 7, 1'b1};
        vecs[5] = '{1, 1'b0, 6'h23, 8'h59, 14'h0000, 1'b0, 1'b0, 7, 1'b1};
        vecs[6] = '{0, 1'b0, 6'h30, 8'h00, 14'h0000, 1'b1, 1'b1, 3, 1'b0};
        vecs[7] = '{1, 1'b1, 6'h23, 8'h5a, 14'h0000, 1'b1, 1'b1, 3, 1'b0};
        vecs[8] = '{0, 1'b1, 6'h00, 8'h00, 14'h0000, 1'b0, 1'b0, 7, 1'b1};

`ifdef ACLK_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif

        #12;
        chk("reset_outputs", {ack, ack_err, busy, H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // Both requesters hold req high through four grants.
        @(negedge clk);
        kind = 2'b00;
        hh_bcd = {6'h22, 6'h11};
        mm_bcd = {8'h22, 8'h11};
        req = 2'b11;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (ack != 2'b00) begin
                grants[ng] = (ack == 2'b10) ? 1 : 0;
                ng++;
                if (ng == 4) begin
                    @(negedge clk);
                    req = 2'b00;
                end
            end
        end
        chk("tie_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk($sformatf("tie_grant_%0d", i), grants[i], exp_g[i]);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("tie_idle", busy, 0);

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Reset while SETTLE is counting: outputs clear at once, no ack afterwards.
        @(negedge clk);
        cmask = '0;
        kind[0] = 1'b0;
        hh_bcd[5:0] = 6'h12;
        mm_bcd[7:0] = 8'h34;
        req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_outputs", {ack, ack_err, busy, H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm}, 0);
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midreset_no_ack", ack, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("after_reset_idle", busy, 0);
        chk("after_reset_no_ack", ack, 0);
        run_txn(vecs[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aclk_load_arbiter.md
Name: aclk_load_arbiter

Overview:
- Configuration controller in front of the aclock core; shares its single load port (digit inputs, LD_time, LD_alarm) between two requesters, e.g. requester 0 = front-panel UI, requester 1 = network time sync.
- Per transaction: validates the BCD hh:mm payload, drives a one-cycle load strobe into aclock, and for time loads reads back H/M outputs to confirm.
- Returns a per-requester ack with an ok/error status.

Parameters:
- SETTLE_CYC, 2: cycles waited after the load strobe before readback compare; legal range 1..15.
- VERIFY_EN_DEF, 1: 1 = time loads are verified by readback; 0 = time loads ack ok after settle without compare.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  2  per-requester request, level; held until that requester's ack.
- kind  in  2  per-requester load type: 0 = time, 1 = alarm.
- hh_bcd  in  12  6 bits per requester, {H1[1:0], H0[3:0]}; requester i uses bits [6i+5:6i].
- mm_bcd  in  16  8 bits per requester, {M1[3:0], M0[3:0]}; requester i uses bits [8i+7:8i].
- ack  out  2  one-cycle completion pulse per requester.
- ack_err  out  1  valid with ack: 1 = rejected or verify mismatch.
- busy  out  1  high in any state other than IDLE.
- H_in1  out  2  to aclock.
- H_in0  out  4  to aclock.
- M_in1  out  4  to aclock.
- M_in0  out  4  to aclock.
- LD_time  out  1  to aclock, one-cycle strobe.
- LD_alarm  out  1  to aclock, one-cycle strobe.
- H_out1  in  2  readback from aclock.
- H_out0  in  4  readback from aclock.
- M_out1  in  4  readback from aclock.
- M_out0  in  4  readback from aclock.

Behaviour:
- Reset (reset=0, asynchronous): state = IDLE; all outputs 0, including digit buses, LD_*, ack, ack_err and busy.
- Reset asserted mid-transaction: outputs clear immediately. The aborted transaction is never acked; the requester must re-request.
- FSM states: IDLE -> CHECK -> LOAD -> SETTLE -> VERIFY -> RESP -> IDLE.
- IDLE: when any req bit is high, select the winner, latch its kind/hh/mm into internal registers and go to CHECK. Payload changes after latch are ignored.
- Arbitration, base build: fixed priority, requester 0 wins when both request in the same cycle.
- CHECK (1 cycle): valid iff H1<=2, H0<=9, (H1==2 implies H0<=3), M1<=5, M0<=9.
  - Invalid: go to RESP with err=1. No strobe is issued and the digit buses stay unchanged.
  - Valid: go to LOAD.
- LOAD (1 cycle): digit buses take the latched value, registered so they are stable in the strobe cycle.
  - LD_time=1 if kind==0, LD_alarm=1 if kind==1; exactly one strobe is high, for exactly one cycle.
  - Digit buses hold their value until the next LOAD; they are not cleared afterwards.
- SETTLE: down-counter loaded with SETTLE_CYC; exit when the count reaches 0.
- VERIFY (1 cycle), applies only when kind==0 and VERIFY_EN_DEF==1:
  - err = ({H_out1,H_out0,M_out1,M_out0} != latched value).
  - Alarm loads, or VERIFY_EN_DEF==0: err=0.
- RESP (1 cycle): ack[winner]=1 and ack_err=err; then return to IDLE.
- The requester must drop req the cycle after ack. A req still high in IDLE is treated as a new request.
- Latency, valid load, request to ack: 1 (IDLE) + 1 (CHECK) + 1 (LOAD) + SETTLE_CYC + 1 (VERIFY) + 1 (RESP). Default = 7 cycles.
- Latency, invalid load: 3 cycles.
- busy is high from CHECK through RESP inclusive.
- A losing requester waits, never starves under round-robin, and its payload is not sampled until it is granted.

Optional Feature:
- Macro: ACLK_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register, reset value 1, so requester 0 wins the first tie. On a tie, the requester not granted last wins; the register updates on every grant.
- Undefined: fixed priority, requester 0 always wins ties; no last-grant register is present.

Test Plan:
- Req0 time 12:34 with aclock model echoing the load -> LD_time pulse 1 cycle with H_in=1/2, M_in=3/4; ack[0]=1, ack_err=0 exactly 7 cycles after req.
- Req1 alarm 07:05 -> LD_alarm pulses once, LD_time stays 0; ack[1]=1, ack_err=0; no readback dependence (force H_out mismatch, still ok).
- Req0 time 24:00, then 19:60 -> no LD pulse, digit buses unchanged; ack[0]=1, ack_err=1, 3 cycles after req each.
- Time load 08:15 with readback forced to 08:16 -> ack_err=1; with VERIFY_EN_DEF=0 -> ack_err=0.
- Both req in same cycle, each re-requesting immediately after ack, for 4 grants:
  - Base build: grants 0,0,0,0.
  - With ACLK_ARB_RR_EN: grants 0,1,0,1.
- Assert reset in the SETTLE cycle -> outputs 0 immediately, no ack; after release, FSM in IDLE and busy=0; a fresh req completes normally.
